micro_seq: RTL and testbench
============================

// Module: micro_seq
// PURPOSE
//  Microprogram sequencer feeding the microinstruction decoder: holds the micro-PC, fetches 9-bit words
//  from a synchronous micro-store ROM, presents them on ms_m for one EXEC cycle and resolves the
//  decoder's cond field against latched ALU flags to pick the next address. Two-word branches: target
//  sits in the word after the branch.
// PARAMETERS
//  ADDR_W       6     micro-store address width (64 words)
//  WORD_W       9     microinstruction width (fixed 9; opcode = [8:6])
//  RESET_VEC    0     micro-PC value after reset
//  STACK_DEPTH  4     return-stack entries (MICRO_CALL_EN only)
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous, active-high reset
//  run       in   1       1 = keep sequencing; 0 = park in IDLE at next instruction boundary
//  flags     in   4       ALU status {V,N,C,Z}
//  cond      in   4       decoder cond output for the current ms_m (combinational loop-back)
//  rom_en    out  1       ROM read strobe
//  rom_addr  out  ADDR_W  ROM address; data valid on rom_q one cycle later
//  rom_q     in   WORD_W  ROM read data
//  ms_m      out  WORD_W  current microinstruction (registered)
//  ms_valid  out  1       1 only in EXEC; qualifies all decoder-driven register enables
//  upc       out  ADDR_W  micro-PC of the word in ms_m
//  halted    out  1       1 in HALT
//  stk_err   out  1       sticky stack over/underflow (constant 0 without MICRO_CALL_EN)
// BEHAVIOUR
//  Reset: state=IDLE, upc=RESET_VEC, ms_m=0, ms_valid=0, halted=0, stk_err=0, sp=0, rom_en=0,
//   rom_addr=RESET_VEC. Reset at any state aborts the instruction; no partial upc update survives.
//  States: IDLE, FETCH, LATCH, EXEC, TFETCH, TLATCH, HALT.
//  IDLE: run=1 -> FETCH. FETCH: rom_en=1, rom_addr=upc -> LATCH. LATCH: ms_m<=rom_q -> EXEC.
//  EXEC: ms_valid=1; flags_q<=flags. ms_m==9'h000 -> HALT. cond==NEXT -> upc<=upc+1.
//   Branch-class cond -> TFETCH (upc unchanged). After upc update: run ? FETCH : IDLE.
//  TFETCH: rom_en=1, rom_addr=upc+1 -> TLATCH. TLATCH: tgt=rom_q[ADDR_W-1:0]; taken ? upc<=tgt :
//   upc<=upc+2; then run ? FETCH : IDLE. ms_m holds the branch word through TFETCH/TLATCH.
//  cond encoding: 0000 JMP, 0001 NEXT, 0010 JZ, 0011 JC, 0100 JN, 0101 JNZ, 0110 CALL, 0111 RET;
//   1xxx treated as NEXT. Flags tested are flags_q (sampled in EXEC).
//  Latency: 3 cycles per sequential word, 5 per branch word. All upc arithmetic mod 2^ADDR_W
//   (upc=63: +1 -> 0, +2 -> 1).
//  HALT: halted=1, ms_valid=0, outputs frozen; exit only via rst. run ignored in HALT.
// CONFIGURATION
//  MICRO_CALL_EN defined: STACK_DEPTH x ADDR_W return stack. CALL (branch-class): push upc+2, upc<=tgt.
//   RET (sequential-class, no target word): pop into upc. Push when full or pop when empty: stk_err<=1,
//   state -> HALT, stack unchanged.
//  Not defined: no stack; 0110/0111 behave as NEXT; stk_err tied 0.
// STRUCTURE
//  Package micro_pkg: cond encodings (COND_JMP..COND_RET), state enum, HALT_WORD=9'h000, OPC_W=3.
//  Sub-module micro_stack (push/pop/full/empty, sync reset), instantiated only under MICRO_CALL_EN.
//  Micro-store ROM stays outside this block.
// TESTING
//  1 ROM[0..2]=9'h0C8,9'h118,9'h000, run=1 -> ms_valid pulses every 3rd cycle, upc 0,1,2, halted=1.
//  2 ROM[4]=JZ (cond 0010), ROM[5]=6'h20; flags Z=1 -> upc=0x20 after 5 cycles; Z=0 -> upc=6.
//  3 upc=63 NEXT -> 0; upc=63 non-taken branch -> target read from addr 0, upc=1.
//  4 run dropped during EXEC -> completes upc update, IDLE, ms_valid=0; run=1 -> resumes at new upc.
//  5 rst asserted in TLATCH -> next cycle IDLE, upc=RESET_VEC, ms_m=0, no branch taken.
//  6 MICRO_CALL_EN, STACK_DEPTH=4: 4 CALLs ok, 5th -> stk_err=1, HALT; RET on empty -> same.

Source files
------------

// File: rtl/micro_pkg.sv
// Shared encodings for the micro-program sequencer: decoder cond codes, FSM states
// and the branch-resolution helpers used by micro_seq.
package micro_pkg;

    localparam int OPC_W = 3;
    localparam logic [8:0] HALT_WORD = 9'h000;

    localparam logic [3:0] COND_JMP  = 4'b0000;
    localparam logic [3:0] COND_NEXT = 4'b0001;
    localparam logic [3:0] COND_JZ   = 4'b0010;
    localparam logic [3:0] COND_JC   = 4'b0011;
    localparam logic [3:0] COND_JN   = 4'b0100;
    localparam logic [3:0] COND_JNZ  = 4'b0101;
    localparam logic [3:0] COND_CALL = 4'b0110;
    localparam logic [3:0] COND_RET  = 4'b0111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_EXEC,
        ST_TFETCH,
        ST_TLATCH,
        ST_HALT
    } state_e;

    // Branch-class words carry a target in the following word; CALL only when the stack exists.
    function automatic logic is_branch(input logic [3:0] c, input logic call_en);
        case (c)
            COND_JMP, COND_JZ, COND_JC, COND_JN, COND_JNZ: is_branch = 1'b1;
            COND_CALL:                                     is_branch = call_en;
            default:                                       is_branch = 1'b0;
        endcase
    endfunction

    // f = {V,N,C,Z}
    function automatic logic cond_taken(input logic [3:0] c, input logic [3:0] f);
        case (c)
            COND_JMP:  cond_taken = 1'b1;
            COND_JZ:   cond_taken = f[0];
            COND_JC:   cond_taken = f[1];
            COND_JN:   cond_taken = f[2];
            COND_JNZ:  cond_taken = ~f[0];
            COND_CALL: cond_taken = 1'b1;
            default:   cond_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/micro_stack.sv
// Return-address stack for micro_seq; push/pop are ignored when full/empty so the
// caller can flag the error while the contents stay untouched.
module micro_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] top;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full  = (sp_q == PTR_W'(DEPTH));
    assign empty = (sp_q == '0);
    assign top   = sp_q - PTR_W'(1);
    assign dout  = mem_q[top[IDX_W-1:0]];

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + PTR_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[sp_q[IDX_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/micro_seq.sv
// Micro-program sequencer: fetches words from an external synchronous micro-store and
// resolves branches against latched ALU flags. Optional return stack: MICRO_CALL_EN.
module micro_seq
    import micro_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int WORD_W    = 9,
    parameter int RESET_VEC = 0
`ifdef MICRO_CALL_EN
    ,
    parameter int STACK_DEPTH = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WORD_W-1:0] rom_q,
    output logic [WORD_W-1:0] ms_m,
    output logic              ms_valid,
    output logic [ADDR_W-1:0] upc,
    output logic              halted,
    output logic              stk_err
);

`ifdef MICRO_CALL_EN
    localparam logic CALL_EN = 1'b1;
`else
    localparam logic CALL_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [WORD_W-1:0] ms_m_q, ms_m_d;
    logic [3:0]        flags_q, flags_d;
    logic [ADDR_W-1:0] upc_p1, upc_p2, tgt;
    state_e            after_upd;

    assign upc_p1    = upc_q + ADDR_W'(1);
    assign upc_p2    = upc_q + ADDR_W'(2);
    assign tgt       = rom_q[ADDR_W-1:0];
    assign after_upd = run ? ST_FETCH : ST_IDLE;

`ifdef MICRO_CALL_EN
    logic              stk_push, stk_pop, stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic              stk_err_q, stk_err_d;

    micro_stack #(
        .DEPTH(STACK_DEPTH),
        .WIDTH(ADDR_W)
    ) u_stack (
        .clk  (clk),
        .rst  (rst),
        .push (stk_push),
        .pop  (stk_pop),
        .din  (upc_p2),
        .dout (stk_top),
        .full (stk_full),
        .empty(stk_empty)
    );

    assign stk_err = stk_err_q;
`else
    assign stk_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        upc_d    = upc_q;
        ms_m_d   = ms_m_q;
        flags_d  = flags_q;
        rom_en   = 1'b0;
        rom_addr = upc_q;
`ifdef MICRO_CALL_EN
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_err_d = stk_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                rom_en  = 1'b1;
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                ms_m_d  = rom_q;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                flags_d = flags;
                if (ms_m_q == HALT_WORD) begin
                    state_d = ST_HALT;
                end else if (is_branch(cond, CALL_EN)) begin
                    state_d = ST_TFETCH;
`ifdef MICRO_CALL_EN
                end else if (cond == COND_RET) begin
                    if (stk_empty) begin
                        stk_err_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        stk_pop = 1'b1;
                        upc_d   = stk_top;
                        state_d = after_upd;
                    end
`endif
                end else begin
                    upc_d   = upc_p1;
                    state_d = after_upd;
                end
            end
            ST_TFETCH: begin
                rom_en   = 1'b1;
                rom_addr = upc_p1;
                state_d  = ST_TLATCH;
            end
            ST_TLATCH: begin
                // ms_m still holds the branch word, so cond is still the branch's cond
`ifdef MICRO_CALL_EN
                if (cond == COND_CALL && stk_full) begin
                    stk_err_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    stk_push = (cond == COND_CALL);
                    upc_d    = cond_taken(cond, flags_q) ? tgt : upc_p2;
                    state_d  = after_upd;
                end
`else
                upc_d   = cond_taken(cond, flags_q) ? tgt : upc_p2;
                state_d = after_upd;
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            upc_q   <= ADDR_W'(RESET_VEC);
            ms_m_q  <= '0;
`ifdef MICRO_CALL_EN
            stk_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ms_m_q  <= ms_m_d;
`ifdef MICRO_CALL_EN
            stk_err_q <= stk_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        flags_q <= flags_d;
    end

    assign ms_m     = ms_m_q;
    assign upc      = upc_q;
    assign ms_valid = (state_q == ST_EXEC);
    assign halted   = (state_q == ST_HALT);

endmodule

// File: tb/tb_micro_seq.sv
// Scoreboard bench for micro_seq: stimulus queues expected EXEC words, a negedge
// monitor pops and compares them as ms_valid pulses.
module tb_micro_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [3:0] flags = 4'h0;
    logic [3:0] cond;
    logic       rom_en;
    logic [5:0] rom_addr;
    logic [8:0] rom_q = 9'h000;
    logic [8:0] ms_m;
    logic       ms_valid;
    logic [5:0] upc;
    logic       halted;
    logic       stk_err;

    logic [8:0] rom [64];

    typedef struct {
        logic [5:0] upc;
        logic [8:0] word;
        int         gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_exec = 0;

    micro_seq dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .flags   (flags),
        .cond    (cond),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_q   (rom_q),
        .ms_m    (ms_m),
        .ms_valid(ms_valid),
        .upc     (upc),
        .halted  (halted),
        .stk_err (stk_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rom_en) rom_q <= rom[rom_addr];

    // Stand-in decoder: cond is the low nibble of the microinstruction
    assign cond = ms_m[3:0];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ms_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_exec: got upc=%0h word=%0h, expected no EXEC", upc, ms_m);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("exec_upc", upc, e.upc);
                check("exec_word", ms_m, e.word);
                if (e.gap != 0) check("exec_gap", cyc - last_exec, e.gap);
            end
            last_exec = cyc;
        end
    end

    task automatic expect_exec(input logic [5:0] u, input logic [8:0] w, input int gap);
        exp_t e;
        e.upc  = u;
        e.word = w;
        e.gap  = gap;
        sb.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 9'h000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input logic [5:0] exp_upc, input logic exp_err);
        int n = 0;
        while (!halted && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("halt_reached", halted, 1);
        check("sb_drained", sb.size(), 0);
        check("halt_upc", upc, exp_upc);
        check("stk_err", stk_err, exp_err);
        repeat (3) @(negedge clk);
        check("halt_frozen_upc", upc, exp_upc);
        check("halt_ms_valid", ms_valid, 0);
        check("halt_stays", halted, 1);
    endtask

    task automatic wait_exec_at(input logic [5:0] u);
        int n = 0;
        while (!(ms_valid && upc == u) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("exec_seen", ms_valid && upc == u, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_rom();

        // reset state
        do_reset();
        check("rst_upc", upc, 0);
        check("rst_ms_m", ms_m, 0);
        check("rst_ms_valid", ms_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_stk_err", stk_err, 0);
        check("rst_rom_en", rom_en, 0);
        check("rst_rom_addr", rom_addr, 0);
        repeat (3) @(negedge clk);
        check("idle_no_run_upc", upc, 0);

        // sequential words then halt
        clear_rom();
        rom[0] = 9'h0C8; rom[1] = 9'h118; rom[2] = 9'h000;
        do_reset();
        expect_exec(0, 9'h0C8, 0);
        expect_exec(1, 9'h118, 3);
        expect_exec(2, 9'h000, 3);
        run = 1'b1;
        wait_halt(2, 0);

        // JZ taken with Z=1
        clear_rom();
        rom[0] = 9'h040; rom[1] = 9'd4; rom[4] = 9'h042; rom[5] = 9'h020;
        do_reset();
        flags = 4'b0001;
        expect_exec(0, 9'h040, 0);
        expect_exec(4, 9'h042, 5);
        expect_exec(6'h20, 9'h000, 5);
        run = 1'b1;
        wait_halt(6'h20, 0);

        // JZ not taken with Z=0
        do_reset();
        flags = 4'b0000;
        expect_exec(0, 9'h040, 0);
        expect_exec(4, 9'h042, 5);
        expect_exec(6, 9'h000, 5);
        run = 1'b1;
        wait_halt(6, 0);

        // JC taken, JN not taken, JNZ taken, stack codes without stack
        clear_rom();
        rom[0] = 9'h043; rom[1] = 9'd8;
        rom[8] = 9'h044; rom[9] = 9'h030;
        rom[10] = 9'h045; rom[11] = 9'd12;
        do_reset();
        flags = 4'b0010;
        expect_exec(0, 9'h043, 0);
        expect_exec(8, 9'h044, 5);
        expect_exec(10, 9'h045, 5);
`ifndef MICRO_CALL_EN
        rom[12] = 9'h046; rom[13] = 9'h047; rom[14] = 9'h000;
        expect_exec(12, 9'h046, 5);
        expect_exec(13, 9'h047, 3);
        expect_exec(14, 9'h000, 3);
        run = 1'b1;
        wait_halt(14, 0);
`else
        expect_exec(12, 9'h000, 5);
        run = 1'b1;
        wait_halt(12, 0);
`endif

        // wrap at 63: NEXT to 62->63, non-taken branch at 63 reads target at 0, lands at 1
        clear_rom();
        rom[0] = 9'h040; rom[1] = 9'd62; rom[62] = 9'h0C8; rom[63] = 9'h042;
        do_reset();
        flags = 4'b0000;
        expect_exec(0, 9'h040, 0);
        expect_exec(62, 9'h0C8, 5);
        expect_exec(63, 9'h042, 3);
        expect_exec(1, 9'h03E, 5);
        expect_exec(2, 9'h000, 3);
        run = 1'b1;
        wait_halt(2, 0);

        // run dropped in EXEC of a NEXT word at 63: wraps to 0, parks in IDLE, then resumes
        clear_rom();
        rom[0] = 9'h040; rom[1] = 9'd63; rom[63] = 9'h0C8;
        do_reset();
        expect_exec(0, 9'h040, 0);
        expect_exec(63, 9'h0C8, 5);
        run = 1'b1;
        wait_exec_at(63);
        run = 1'b0;
        @(negedge clk);
        check("park_upc", upc, 0);
        check("park_ms_valid", ms_valid, 0);
        check("park_rom_en", rom_en, 0);
        repeat (4) @(negedge clk);
        check("park_hold_upc", upc, 0);
        check("park_hold_ms_valid", ms_valid, 0);
        check("park_sb_drained", sb.size(), 0);
        rom[0] = 9'h118; rom[1] = 9'h000;
        expect_exec(0, 9'h118, 0);
        expect_exec(1, 9'h000, 3);
        run = 1'b1;
        wait_halt(1, 0);

        // reset during TLATCH aborts the branch
        clear_rom();
        rom[0] = 9'h040; rom[1] = 9'h020;
        do_reset();
        expect_exec(0, 9'h040, 0);
        run = 1'b1;
        wait_exec_at(0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        @(negedge clk);
        check("tl_rst_upc", upc, 0);
        check("tl_rst_ms_m", ms_m, 0);
        check("tl_rst_ms_valid", ms_valid, 0);
        check("tl_rst_halted", halted, 0);
        check("tl_rst_rom_en", rom_en, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("tl_rst_no_branch_upc", upc, 0);
        check("tl_rst_sb_drained", sb.size(), 0);

`ifdef MICRO_CALL_EN
        // CALL then RET returns to call address + 2
        clear_rom();
        rom[0] = 9'h046; rom[1] = 9'd4; rom[4] = 9'h047; rom[2] = 9'h000;
        do_reset();
        expect_exec(0, 9'h046, 0);
        expect_exec(4, 9'h047, 5);
        expect_exec(2, 9'h000, 3);
        run = 1'b1;
        wait_halt(2, 0);

        // fifth nested CALL overflows
        clear_rom();
        for (int i = 0; i < 5; i++) begin
            rom[4*i]     = 9'h046;
            rom[4*i + 1] = 9'(4*i + 4);
        end
        do_reset();
        expect_exec(0, 9'h046, 0);
        for (int i = 1; i < 5; i++) expect_exec(6'(4*i), 9'h046, 5);
        run = 1'b1;
        wait_halt(16, 1);

        // RET on empty stack underflows
        clear_rom();
        rom[0] = 9'h047;
        do_reset();
        check("err_cleared_by_rst", stk_err, 0);
        expect_exec(0, 9'h047, 0);
        run = 1'b1;
        wait_halt(0, 1);
`endif

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
